alu_cmd_driver: RTL and testbench
=================================

# alu_cmd_driver

Initiator-side front end for the 4-bit ALU. Accepts one operation request at a time over a valid/ready handshake and drives the ALU's opcode and operand inputs, holding them stable. It waits the ALU's register latency, captures the 5-bit signed result, and returns it with status flags over a second valid/ready handshake. It also keeps saturating counters of completed and out-of-range operations for bring-up and debug.

## Interface
- `ALU_LATENCY`, 1: edges between the ALU inputs changing and `C` reflecting them; range 1..7
- `CNT_W`, 8: width of the debug counters
- `clk` in 1: single clock; everything is rising-edge
- `reset` in 1: synchronous, active-high; also wired to the ALU's `reset`
- `req_valid` in 1: request present
- `req_ready` out 1: driver can accept a request
- `req_opcode` in 2: 00 add, 01 sub, 10 not A, 11 reduction-OR B
- `req_a` in 4: operand A, two's complement
- `req_b` in 4: operand B, two's complement
- `alu_opcode` out 2: to ALU `Opcode`
- `alu_a` out 4: to ALU `A`
- `alu_b` out 4: to ALU `B`
- `alu_c` in 5: from ALU `C`, signed
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: consumer takes response
- `rsp_result` out 5: captured `alu_c`, signed
- `rsp_ovf4` out 1: result outside -8..7 (not representable in 4 bits)
- `rsp_zero` out 1: result == 0
- `rsp_neg` out 1: result bit 4 set
- `done_count` out CNT_W: completed responses, saturating
- `ovf_count` out CNT_W: completed responses with `rsp_ovf4`, saturating

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, load `alu_opcode`/`alu_a`/`alu_b` from the request, load the wait counter with `ALU_LATENCY`, and go to WAIT.
  - WAIT: `req_ready`=0. Each edge: if the counter is 0, capture `alu_c` into `rsp_result`, compute the flags, and go to RESP; otherwise decrement.
  - RESP: `rsp_valid`=1. On `rsp_ready`, increment the counters and go to IDLE.
- ALU drive registers hold their value until the next accepted request; they are never changed outside an accept.
- Exactly one operation is in flight; no pipelining or buffering beyond the single response register.
- Flags are derived from the captured 5-bit value only; the driver does not recompute ALU arithmetic.
- Counters saturate at 2^CNT_W-1 and never wrap.
- `ovf_count` increments only on a handshake whose `rsp_ovf4`=1.

## Timing
- Reset values (asserted at any edge, including mid-WAIT or mid-RESP): state IDLE; `req_ready`=1 on the first cycle after reset; all of the following are 0:
  - `rsp_valid`, `rsp_result`, all flags
  - `alu_opcode`, `alu_a`, `alu_b`
  - both counters

  An in-flight operation is dropped silently with no response.
- Let the accept edge be E0. `alu_*` take the new values after E0, and `alu_c` is captured at edge E0+ALU_LATENCY+1. With the default latency, `rsp_valid` rises after E2.
- The response handshake edge is Eh. `req_ready` rises after Eh, so the next accept is at Eh+1 at the earliest.
- Sustained throughput is one operation per ALU_LATENCY+3 cycles.
- While `rsp_valid`=1 and `rsp_ready`=0, `rsp_result` and the flags are held stable.
- `req_ready`=0 in WAIT and RESP. Requests presented there are not accepted, and the requester must hold them.
- `reset` asserted together with `req_valid`: reset wins and nothing is accepted.

## Structure
- Shared package `alu_pkg` holds:
  - opcode enum `alu_op_e` (`OP_ADD`, `OP_SUB`, `OP_NOT_A`, `OP_RED_OR_B`)
  - `DATA_W`=4 and `RES_W`=5
  - the limits `MAXPOS`=7 and `MAXNEG`=-8
  - the FSM state enum
- One sub-module, `sat_counter` (parameter W; inputs inc and clear), instantiated twice for the debug counters.

## Test plan
- Reset during WAIT (req add 7,7 then `reset` at E1) -> no response, `alu_a`=0, counters 0, `req_ready`=1 the cycle after reset.
- Add, A=7, B=-8, `rsp_ready` held 1 -> `rsp_valid` after E2, `rsp_result`=-1, `rsp_neg`=1, `rsp_ovf4`=0, `done_count`=1.
- Sub, A=7, B=-8 -> `rsp_result`=15, `rsp_ovf4`=1, `ovf_count`=1.
- Add, A=-8, B=-8 -> `rsp_result`=-16, `rsp_ovf4`=1, `rsp_neg`=1.
- Not A with A=7, then reduction-OR B with B=0 -> results -8 then 0 (`rsp_zero`=1). Hold `rsp_ready`=0 for 3 cycles on the first: the result stays stable and `req_ready` stays 0 while a second request waits.
- Back-to-back requests with `ALU_LATENCY`=3 -> accepts exactly 6 cycles apart.
- `CNT_W`=2, 5 ops -> `done_count`=3 (saturated).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-bit ALU command driver.
// Holds the opcode and FSM enums plus the result range check used for the overflow flag.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int RES_W  = 5;
    localparam int MAXPOS = 7;
    localparam int MAXNEG = -8;

    typedef enum logic [1:0] {
        OP_ADD      = 2'b00,
        OP_SUB      = 2'b01,
        OP_NOT_A    = 2'b10,
        OP_RED_OR_B = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // True when a 5-bit ALU result cannot be represented in 4 signed bits.
    function automatic logic out_of_range(input logic signed [RES_W-1:0] v);
        int w_v;
        w_v = int'(v);
        return (w_v > MAXPOS) || (w_v < MAXNEG);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator front end for the 4-bit ALU: one request in flight, waits the ALU latency,
// captures the signed result with flags and returns it over a response handshake.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_opcode,
    input  logic [3:0]       req_a,
    input  logic [3:0]       req_b,
    output logic [1:0]       alu_opcode,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [4:0]       alu_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [4:0]       rsp_result,
    output logic             rsp_ovf4,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic [CNT_W-1:0] done_count,
    output logic [CNT_W-1:0] ovf_count
);

    state_e                  r_state;
    state_e                  w_next_state;
    logic [2:0]              r_wait;
    logic [1:0]              r_opcode;
    logic [DATA_W-1:0]       r_a;
    logic [DATA_W-1:0]       r_b;
    logic signed [RES_W-1:0] r_result;
    logic                    r_ovf;
    logic                    r_zero;
    logic                    r_neg;
    logic                    w_accept;
    logic                    w_capture;
    logic                    w_rsp_done;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wait == 3'd0) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_done   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // The wait counter spans ALU_LATENCY+1 edges so capture lands one edge after C settles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_wait   <= 3'd0;
            r_opcode <= 2'b00;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_opcode <= req_opcode;
                r_a      <= req_a;
                r_b      <= req_b;
                r_wait   <= 3'(ALU_LATENCY);
            end else if ((r_state == ST_WAIT) && !w_capture) begin
                r_wait <= r_wait - 3'd1;
            end
            if (w_capture) begin
                r_result <= $signed(alu_c);
                r_ovf    <= out_of_range($signed(alu_c));
                r_zero   <= (alu_c == 5'd0);
                r_neg    <= alu_c[RES_W-1];
            end
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign rsp_valid  = (r_state == ST_RESP);
    assign alu_opcode = r_opcode;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign rsp_result = r_result;
    assign rsp_ovf4   = r_ovf;
    assign rsp_zero   = r_zero;
    assign rsp_neg    = r_neg;

    sat_counter #(.W(CNT_W)) u_done_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (w_rsp_done),
        .count (done_count)
    );

    sat_counter #(.W(CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (w_rsp_done && r_ovf),
        .count (ovf_count)
    );

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver: a latency-1 instance for function/flags/reset/hold
// and a latency-3, 2-bit-counter instance for back-to-back spacing and saturation.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    typedef struct packed {
        logic [4:0] res;
        logic       ovf;
        logic       zero;
        logic       neg;
    } exp_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    int   cyc;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ga, ea, gb, eb;

    // Instance A: latency 1, 8-bit counters
    logic       a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [1:0] a_req_opcode, a_alu_opcode;
    logic [3:0] a_req_a, a_req_b, a_alu_a, a_alu_b;
    logic [4:0] a_alu_c, a_rsp_result;
    logic       a_rsp_ovf4, a_rsp_zero, a_rsp_neg;
    logic [7:0] a_done_count, a_ovf_count;

    // Instance B: latency 3, 2-bit counters
    logic       b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [1:0] b_req_opcode, b_alu_opcode;
    logic [3:0] b_req_a, b_req_b, b_alu_a, b_alu_b;
    logic [4:0] b_alu_c, b_rsp_result, b_p1, b_p2;
    logic       b_rsp_ovf4, b_rsp_zero, b_rsp_neg;
    logic [1:0] b_done_count, b_ovf_count;

    alu_cmd_driver #(.ALU_LATENCY(1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_opcode(a_req_opcode), .req_a(a_req_a), .req_b(a_req_b),
        .alu_opcode(a_alu_opcode), .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_c(a_alu_c),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_result(a_rsp_result),
        .rsp_ovf4(a_rsp_ovf4), .rsp_zero(a_rsp_zero), .rsp_neg(a_rsp_neg),
        .done_count(a_done_count), .ovf_count(a_ovf_count)
    );

    alu_cmd_driver #(.ALU_LATENCY(3), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_opcode(b_req_opcode), .req_a(b_req_a), .req_b(b_req_b),
        .alu_opcode(b_alu_opcode), .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_c(b_alu_c),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_result(b_rsp_result),
        .rsp_ovf4(b_rsp_ovf4), .rsp_zero(b_rsp_zero), .rsp_neg(b_rsp_neg),
        .done_count(b_done_count), .ovf_count(b_ovf_count)
    );

    // Behavioural 4-bit ALU
    function automatic logic [4:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic signed [4:0] ea5, eb5;
        ea5 = {a[3], a};
        eb5 = {b[3], b};
        case (op)
            2'b00:   return ea5 + eb5;
            2'b01:   return ea5 - eb5;
            2'b10:   return ~ea5;
            default: return {4'b0000, |b};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            a_alu_c <= '0;
            b_p1    <= '0;
            b_p2    <= '0;
            b_alu_c <= '0;
        end else begin
            a_alu_c <= alu_f(a_alu_opcode, a_alu_a, a_alu_b);
            b_p1    <= alu_f(b_alu_opcode, b_alu_a, b_alu_b);
            b_p2    <= b_p1;
            b_alu_c <= b_p2;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Response monitors: compare each handshaken response against the queue head
    always @(negedge clk) begin
        if (!reset && a_rsp_valid && a_rsp_ready) begin
            ga = '{a_rsp_result, a_rsp_ovf4, a_rsp_zero, a_rsp_neg};
            n_chk++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL a_unexpected_rsp got=%h required=none", ga);
            end else begin
                ea = qa.pop_front();
                if (ga !== ea) begin
                    n_fail++;
                    $display("FAIL a_rsp got res=%0d ovf=%b zero=%b neg=%b required res=%0d ovf=%b zero=%b neg=%b",
                             $signed(ga.res), ga.ovf, ga.zero, ga.neg, $signed(ea.res), ea.ovf, ea.zero, ea.neg);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && b_rsp_valid && b_rsp_ready) begin
            gb = '{b_rsp_result, b_rsp_ovf4, b_rsp_zero, b_rsp_neg};
            n_chk++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected_rsp got=%h required=none", gb);
            end else begin
                eb = qb.pop_front();
                if (gb !== eb) begin
                    n_fail++;
                    $display("FAIL b_rsp got res=%0d ovf=%b zero=%b neg=%b required res=%0d ovf=%b zero=%b neg=%b",
                             $signed(gb.res), gb.ovf, gb.zero, gb.neg, $signed(eb.res), eb.ovf, eb.zero, eb.neg);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // Present a request on A and return 1 time unit after the accepting edge
    task automatic send_a(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int n;
        a_req_opcode = op;
        a_req_a      = a;
        a_req_b      = b;
        a_req_valid  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_req_ready && n < 50);
        chk("a_accept_within_bound", 32'(a_req_ready), 32'd1);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
    endtask

    // Number of negedges until A shows rsp_valid (bounded)
    task automatic wait_valid_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_rsp_valid && n < 50);
    endtask

    int acc[5];
    int lat;

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        reset = 1'b1;
        a_req_valid = 0; a_req_opcode = 0; a_req_a = 0; a_req_b = 0; a_rsp_ready = 1'b1;
        b_req_valid = 0; b_req_opcode = 0; b_req_a = 0; b_req_b = 0; b_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        // Reset with a request pending: nothing may be accepted
        a_req_valid = 1'b1; a_req_opcode = OP_ADD; a_req_a = 4'd3; a_req_b = 4'd3;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_bits", {24'd0, a_rsp_result, a_rsp_ovf4, a_rsp_zero, a_rsp_neg}, 32'd0);
        chk("rst_alu_drive", {22'd0, a_alu_opcode, a_alu_a, a_alu_b}, 32'd0);
        chk("rst_counts", {16'd0, a_done_count, a_ovf_count}, 32'd0);

        // Reset in the middle of WAIT drops the operation
        @(posedge clk); #1;
        send_a(OP_ADD, 4'd7, 4'd7);
        chk("wait_alu_a_loaded", 32'(a_alu_a), 32'd7);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midwait_req_ready", 32'(a_req_ready), 32'd1);
        chk("midwait_alu_a", 32'(a_alu_a), 32'd0);
        chk("midwait_counts", {16'd0, a_done_count, a_ovf_count}, 32'd0);
        repeat (4) @(negedge clk);
        chk("midwait_no_rsp", 32'(a_rsp_valid), 32'd0);

        // Add 7 + -8 = -1
        @(posedge clk); #1;
        qa.push_back('{5'b11111, 1'b0, 1'b0, 1'b1});
        send_a(OP_ADD, 4'd7, 4'b1000);
        wait_valid_a(lat);
        chk("add_latency_negedges", 32'(lat), 32'd3);
        @(negedge clk);
        chk("add_done_count", 32'(a_done_count), 32'd1);
        chk("add_ovf_count", 32'(a_ovf_count), 32'd0);

        // Sub 7 - -8 = 15 (overflow)
        @(posedge clk); #1;
        qa.push_back('{5'b01111, 1'b1, 1'b0, 1'b0});
        send_a(OP_SUB, 4'd7, 4'b1000);
        wait_valid_a(lat);
        @(negedge clk);
        chk("sub_done_count", 32'(a_done_count), 32'd2);
        chk("sub_ovf_count", 32'(a_ovf_count), 32'd1);

        // Add -8 + -8 = -16 (overflow, negative)
        @(posedge clk); #1;
        qa.push_back('{5'b10000, 1'b1, 1'b0, 1'b1});
        send_a(OP_ADD, 4'b1000, 4'b1000);
        wait_valid_a(lat);
        @(negedge clk);
        chk("addneg_ovf_count", 32'(a_ovf_count), 32'd2);

        // Not A (7 -> -8) held 3 cycles with a second request waiting, then red-OR B=0
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
        qa.push_back('{5'b11000, 1'b0, 1'b0, 1'b1});
        send_a(OP_NOT_A, 4'd7, 4'd5);
        wait_valid_a(lat);
        chk("nota_valid_seen", 32'(a_rsp_valid), 32'd1);
        @(posedge clk); #1;
        a_req_opcode = OP_RED_OR_B; a_req_a = 4'd9; a_req_b = 4'd0; a_req_valid = 1'b1;
        qa.push_back('{5'b00000, 1'b0, 1'b1, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_result", {26'd0, a_rsp_valid, a_rsp_result}, {26'd0, 1'b1, 5'b11000});
            chk("hold_req_ready", 32'(a_req_ready), 32'd0);
        end
        @(posedge clk); #1;
        a_rsp_ready = 1'b1;
        send_a(OP_RED_OR_B, 4'd9, 4'd0);
        wait_valid_a(lat);
        @(negedge clk);
        chk("final_done_count", 32'(a_done_count), 32'd5);
        chk("final_ovf_count", 32'(a_ovf_count), 32'd2);

        // Instance B: back-to-back at latency 3, counters saturate at 3
        begin
            logic [1:0] ops[5];
            logic [3:0] as[5], bs[5];
            exp_t       ex[5];
            int         n;
            ops = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11};
            as  = '{4'd1, 4'd3, 4'd7, 4'd0, 4'd0};
            bs  = '{4'd2, 4'd5, 4'd7, 4'd0, 4'd5};
            ex  = '{'{5'd3, 1'b0, 1'b0, 1'b0}, '{5'b11110, 1'b0, 1'b0, 1'b1},
                    '{5'd14, 1'b1, 1'b0, 1'b0}, '{5'b11111, 1'b0, 1'b0, 1'b1},
                    '{5'd1, 1'b0, 1'b0, 1'b0}};
            @(posedge clk); #1;
            for (int i = 0; i < 5; i++) begin
                b_req_opcode = ops[i]; b_req_a = as[i]; b_req_b = bs[i];
                b_req_valid  = 1'b1;
                qb.push_back(ex[i]);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!b_req_ready && n < 50);
                chk("b_accept_within_bound", 32'(b_req_ready), 32'd1);
                @(posedge clk); #1;
                acc[i] = cyc;
            end
            b_req_valid = 1'b0;
            for (int i = 1; i < 5; i++) chk("b_accept_spacing", 32'(acc[i] - acc[i-1]), 32'd6);
            n = 0;
            while (qb.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("b_queue_drained", 32'(qb.size()), 32'd0);
            @(negedge clk);
            chk("b_done_saturated", 32'(b_done_count), 32'd3);
            chk("b_ovf_count", 32'(b_ovf_count), 32'd1);
        end

        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
